csa_stream_accumulator: RTL and testbench
=========================================

Name: csa_stream_accumulator

Overview:
Multi-operand unsigned accumulator built around a 3:2 carry-save compressor. Operands stream in over a valid/ready handshake. Each accepted operand is folded into a redundant sum/carry register pair in one cycle, with no carry propagation on the accumulate path. On the last operand, a chunked sequential carry-propagate stage resolves the redundant pair. The block then presents the binary total, the operand count and a sticky overflow flag. It sits in the multiplier datapath where partial products arrive serially.

Parameters:
DATA_SIZE_IN, 8, operand width (unsigned, zero-extended to DATA_SIZE_ACC)
DATA_SIZE_ACC, 16, accumulator / result width; must be > DATA_SIZE_IN
CPA_CHUNK, 4, bits resolved per cycle in the final adder; DATA_SIZE_ACC must be a multiple of CPA_CHUNK
COUNT_SIZE, 8, operand counter width

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  asynchronous active-high reset
clear_i  input  1  synchronous abort: discard accumulation, return to ACCUM
in_valid_i  input  1  operand valid
in_ready_o  output  1  block can accept an operand
in_data_i  input  DATA_SIZE_IN  operand
in_last_i  input  1  marks final operand of a group (sampled with the transfer)
out_valid_o  output  1  result valid
out_ready_i  input  1  result consumed
sum_o  output  DATA_SIZE_ACC  total modulo 2^DATA_SIZE_ACC
count_o  output  COUNT_SIZE  operands accepted in the group (saturating)
overflow_o  output  1  true total >= 2^DATA_SIZE_ACC

Behaviour:
- Reset (async, rst_i=1): state=ACCUM; U, V, count, overflow, chunk index, carry = 0; sum_o=0, count_o=0, overflow_o=0, out_valid_o=0, in_ready_o=1. Reset takes effect at any state, including mid-RESOLVE; the partial result is lost.
- Internal: U, V registers of DATA_SIZE_ACC bits (redundant pair; invariant: U+V = accumulated total mod 2^DATA_SIZE_ACC).
- States: ACCUM, RESOLVE, DONE. in_ready_o=1 only in ACCUM; out_valid_o=1 only in DONE.
- ACCUM, on transfer (in_valid_i & in_ready_o):
  - x = zero-extended in_data_i.
  - U' = x^U^V.
  - V' = {maj(x,U,V)[ACC-2:0], 0}.
  - Bit positions >= DATA_SIZE_IN use the 2-input (U,V) compressor, not x.
  - If maj bit ACC-1 is 1, set overflow (sticky).
  - count increments, saturating at 2^COUNT_SIZE-1.
  - If in_last_i=1, next state is RESOLVE with chunk index=0 and carry=0.
- RESOLVE: one cycle per chunk, LSB chunk first. Add U and V slices of CPA_CHUNK bits plus carry; write the result into the slice of sum_o; carry out feeds the next chunk. Final chunk carry-out=1 sets overflow. After DATA_SIZE_ACC/CPA_CHUNK cycles, go to DONE.
- Latency: last operand accepted on edge t -> out_valid_o=1 from edge t+DATA_SIZE_ACC/CPA_CHUNK+1 (default 5 cycles).
- DONE: sum_o, count_o and overflow_o are stable while out_valid_o=1 and out_ready_i=0. On out_ready_i=1:
  - U, V, count and overflow clear;
  - next state is ACCUM;
  - sum_o, count_o and overflow_o keep their values until the next result;
  - out_valid_o drops the following cycle.
- in_valid_i is ignored outside ACCUM; in_data_i and in_last_i are don't-care then.
- clear_i=1 (any state, synchronous, priority over all other events in that cycle): same values as reset except sum_o/count_o/overflow_o hold; next state is ACCUM.
- A transfer in the same cycle as clear_i is dropped.
- A group of one operand (in_last_i on the first transfer) is legal.
- Back-to-back groups: the first operand of the next group is accepted the cycle after the DONE handshake.

Test Plan:
- Defaults; operands 0xFF, 0xFF, 0xFF (last on third) -> out_valid_o 5 cycles after last transfer; sum_o=0x02FD, count_o=3, overflow_o=0.
- Single operand 0x80 with in_last_i=1 -> sum_o=0x0080, count_o=1, overflow_o=0.
- 258 operands of 0xFF -> sum_o=0x00FE, count_o=255 (saturated), overflow_o=1.
- Result backpressure: out_ready_i=0 for 10 cycles, with in_valid_i=1 and in_data_i=0x11 the whole time -> in_ready_o=0, outputs constant, no operand accepted. Then out_ready_i=1 -> in_ready_o=1 next cycle. Next group 0x01 (last) -> sum_o=0x0001.
- Reset asserted during the 2nd RESOLVE cycle -> all outputs 0 immediately, in_ready_o=1. Then operand 0x05 (last) -> sum_o=0x0005, count_o=1.
- Operands 0x10, 0x20; clear_i pulse; then 0x03 (last) -> sum_o=0x0003, count_o=1, overflow_o=0.

Source files
------------

// File: rtl/csa_stream_accumulator_if.sv
// Stream-in / result-out bundle for csa_stream_accumulator.
// master: operand producer and result consumer. slave: the accumulator.
interface csa_stream_accumulator_if #(
    parameter int DATA_SIZE_IN  = 8,
    parameter int DATA_SIZE_ACC = 16,
    parameter int COUNT_SIZE    = 8
);
    logic                     clear_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [DATA_SIZE_IN-1:0]  in_data_i;
    logic                     in_last_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [DATA_SIZE_ACC-1:0] sum_o;
    logic [COUNT_SIZE-1:0]    count_o;
    logic                     overflow_o;

    modport master (
        output clear_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, count_o, overflow_o
    );

    modport slave (
        input  clear_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, count_o, overflow_o
    );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Multi-operand unsigned accumulator. Operands are folded into a redundant
// U/V pair by a 3:2 compressor (no carry chain on the accept path); the last
// operand of a group triggers a chunked ripple resolve of U+V into sum_o.
module csa_stream_accumulator #(
    parameter int DATA_SIZE_IN  = 8,
    parameter int DATA_SIZE_ACC = 16,
    parameter int CPA_CHUNK     = 4,
    parameter int COUNT_SIZE    = 8
) (
    input logic                    clk_i,
    input logic                    rst_i,
    csa_stream_accumulator_if.slave bus
);
    localparam int NCHUNK = DATA_SIZE_ACC / CPA_CHUNK;
    // Index runs 0..NCHUNK: NCHUNK add cycles plus one commit cycle.
    localparam int IDX_W  = $clog2(NCHUNK + 1);

    typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;

    state_t                   state_q, state_d;
    logic [DATA_SIZE_ACC-1:0] u_q, v_q, sum_q;
    logic [DATA_SIZE_ACC-1:0] u_csa, maj;
    logic [COUNT_SIZE-1:0]    count_q, count_out_q;
    logic                     ovf_q, ovf_out_q, carry_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     xfer;
    logic [CPA_CHUNK-1:0]     u_slice, v_slice;
    logic [CPA_CHUNK:0]       chunk_sum;

    // Clear wins over a same-cycle transfer, so the operand is dropped.
    assign xfer = bus.in_valid_i && (state_q == ACCUM) && !bus.clear_i;

    // Per-bit compressor: full 3:2 where the operand has bits, 2:2 above it.
    for (genvar b = 0; b < DATA_SIZE_ACC; b++) begin : g_csa
        if (b < DATA_SIZE_IN) begin : g_full
            assign u_csa[b] = bus.in_data_i[b] ^ u_q[b] ^ v_q[b];
            assign maj[b]   = (bus.in_data_i[b] & u_q[b]) |
                              (bus.in_data_i[b] & v_q[b]) | (u_q[b] & v_q[b]);
        end else begin : g_half
            assign u_csa[b] = u_q[b] ^ v_q[b];
            assign maj[b]   = u_q[b] & v_q[b];
        end
    end

    // Current resolve chunk, selected by shifting so idx==NCHUNK stays in range.
    assign u_slice   = CPA_CHUNK'(u_q >> (32'(idx_q) * CPA_CHUNK));
    assign v_slice   = CPA_CHUNK'(v_q >> (32'(idx_q) * CPA_CHUNK));
    assign chunk_sum = {1'b0, u_slice} + {1'b0, v_slice} + {{CPA_CHUNK{1'b0}}, carry_q};

    assign bus.in_ready_o  = (state_q == ACCUM);
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.sum_o       = sum_q;
    assign bus.count_o     = count_out_q;
    assign bus.overflow_o  = ovf_out_q;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    // Next-state logic; clear overrides every other event.
    always_comb begin
        state_d = state_q;
        if (bus.clear_i) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (xfer && bus.in_last_i) state_d = RESOLVE;
                RESOLVE: if (idx_q == IDX_W'(NCHUNK)) state_d = DONE;
                DONE:    if (bus.out_ready_i) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Datapath: accumulate, chunked resolve, result commit and release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            u_q         <= '0;
            v_q         <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            count_out_q <= '0;
            ovf_out_q   <= 1'b0;
        end else if (bus.clear_i) begin
            u_q     <= '0;
            v_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (xfer) begin
                        u_q <= u_csa;
                        v_q <= {maj[DATA_SIZE_ACC-2:0], 1'b0};
                        // Carry shifted out of the top is weight 2^ACC: lost total.
                        if (maj[DATA_SIZE_ACC-1]) ovf_q <= 1'b1;
                        if (count_q != '1) count_q <= count_q + COUNT_SIZE'(1);
                        if (bus.in_last_i) begin
                            idx_q   <= '0;
                            carry_q <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    if (idx_q < IDX_W'(NCHUNK)) begin
                        for (int c = 0; c < NCHUNK; c++)
                            if (idx_q == IDX_W'(c))
                                sum_q[c*CPA_CHUNK +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
                        carry_q <= chunk_sum[CPA_CHUNK];
                        if (idx_q == IDX_W'(NCHUNK - 1) && chunk_sum[CPA_CHUNK]) ovf_q <= 1'b1;
                        idx_q <= idx_q + IDX_W'(1);
                    end else begin
                        // Commit cycle: publish count and the final sticky overflow.
                        count_out_q <= count_q;
                        ovf_out_q   <= ovf_q;
                        idx_q       <= '0;
                        carry_q     <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        u_q     <= '0;
                        v_q     <= '0;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Directed + randomized bench for csa_stream_accumulator. The reference is a
// plain integer sum of each group's operands.
module tb_csa_stream_accumulator;
    localparam int NCHUNK = 16 / 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] ops[$];

    csa_stream_accumulator_if #(.DATA_SIZE_IN(8), .DATA_SIZE_ACC(16), .COUNT_SIZE(8)) bus ();

    csa_stream_accumulator #(
        .DATA_SIZE_IN(8), .DATA_SIZE_ACC(16), .CPA_CHUNK(4), .COUNT_SIZE(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand from a negedge; returns on the negedge after it transfers.
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.in_last_i  = last;
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(bus.in_ready_o), 32'(1));
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    // Stream the ops queue as one group, check the result against the integer
    // model, hold the result for 'hold' cycles (optionally poking in_valid), release.
    task automatic run_ops(input int hold, input bit poke);
        longint     total = 0;
        int         n     = ops.size();
        int         lat   = 0;
        logic [15:0] es;
        logic [7:0]  ec;
        logic        eo;
        for (int i = 0; i < n; i++) begin
            total += longint'(ops[i]);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send(ops[i], (i == n - 1));
        end
        es = 16'(total);
        ec = (n > 255) ? 8'd255 : 8'(n);
        eo = (total >= 65536);
        while (!bus.out_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(NCHUNK + 1));
        check("sum", 32'(bus.sum_o), 32'(es));
        check("count", 32'(bus.count_o), 32'(ec));
        check("overflow", 32'(bus.overflow_o), 32'(eo));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid_i = poke;
            bus.in_data_i  = 8'h11;
            @(negedge clk);
            check("hold_in_ready", 32'(bus.in_ready_o), 32'(0));
            check("hold_out_valid", 32'(bus.out_valid_o), 32'(1));
            check("hold_sum", 32'(bus.sum_o), 32'(es));
            check("hold_count", 32'(bus.count_o), 32'(ec));
            check("hold_overflow", 32'(bus.overflow_o), 32'(eo));
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        check("release_out_valid", 32'(bus.out_valid_o), 32'(0));
        check("release_in_ready", 32'(bus.in_ready_o), 32'(1));
        check("release_sum_held", 32'(bus.sum_o), 32'(es));
        check("release_count_held", 32'(bus.count_o), 32'(ec));
    endtask

    initial begin
        rst             = 1'b1;
        bus.clear_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 8'h00;
        bus.in_last_i   = 1'b0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready_o), 32'(1));
        check("rst_out_valid", 32'(bus.out_valid_o), 32'(0));
        check("rst_sum", 32'(bus.sum_o), 32'(0));
        check("rst_count", 32'(bus.count_o), 32'(0));
        check("rst_overflow", 32'(bus.overflow_o), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // Three 0xFF operands.
        ops = '{8'hFF, 8'hFF, 8'hFF};
        run_ops(0, 1'b0);
        check("t1_sum", 32'(bus.sum_o), 32'h02FD);
        check("t1_count", 32'(bus.count_o), 32'd3);

        // Single-operand group.
        ops = '{8'h80};
        run_ops(0, 1'b0);
        check("t2_sum", 32'(bus.sum_o), 32'h0080);

        // 258 x 0xFF: count saturates, total wraps.
        ops.delete();
        for (int i = 0; i < 258; i++) ops.push_back(8'hFF);
        run_ops(0, 1'b0);
        check("t3_sum", 32'(bus.sum_o), 32'h00FE);
        check("t3_count", 32'(bus.count_o), 32'd255);
        check("t3_overflow", 32'(bus.overflow_o), 32'd1);

        // Result backpressure with in_valid held high on 0x11.
        ops = '{8'h22, 8'h33};
        run_ops(10, 1'b1);
        ops = '{8'h01};
        run_ops(0, 1'b0);
        check("t4_sum", 32'(bus.sum_o), 32'h0001);
        check("t4_count", 32'(bus.count_o), 32'd1);

        // Asynchronous reset during the second resolve cycle.
        send(8'h30, 1'b0);
        send(8'h40, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_sum", 32'(bus.sum_o), 32'(0));
        check("t5_rst_count", 32'(bus.count_o), 32'(0));
        check("t5_rst_overflow", 32'(bus.overflow_o), 32'(0));
        check("t5_rst_out_valid", 32'(bus.out_valid_o), 32'(0));
        check("t5_rst_in_ready", 32'(bus.in_ready_o), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ops = '{8'h05};
        run_ops(0, 1'b0);
        check("t5_sum", 32'(bus.sum_o), 32'h0005);
        check("t5_count", 32'(bus.count_o), 32'd1);

        // Clear mid-group; the same-cycle transfer (marked last) is dropped.
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        bus.clear_i    = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h40;
        bus.in_last_i  = 1'b1;
        @(negedge clk);
        bus.clear_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        check("t6_clr_in_ready", 32'(bus.in_ready_o), 32'(1));
        check("t6_clr_out_valid", 32'(bus.out_valid_o), 32'(0));
        check("t6_clr_sum_held", 32'(bus.sum_o), 32'h0005);
        check("t6_clr_count_held", 32'(bus.count_o), 32'd1);
        ops = '{8'h03};
        run_ops(0, 1'b0);
        check("t6_sum", 32'(bus.sum_o), 32'h0003);
        check("t6_count", 32'(bus.count_o), 32'd1);
        check("t6_overflow", 32'(bus.overflow_o), 32'd0);

        // Random groups with random backpressure.
        for (int g = 0; g < 10; g++) begin
            ops.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                ops.push_back(8'($urandom_range(0, 255)));
            run_ops(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Long random group of large operands: saturation and overflow paths.
        ops.delete();
        for (int i = 0; i < 300; i++) ops.push_back(8'($urandom_range(200, 255)));
        run_ops(2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
